// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush controller
//
// Contents:
//   state_e    controller FSM states (RUN / MEM_WAIT / ERROR, encoding 3 unused)
//   REG_IDX_W  architectural register index width
//   NOP_INSTR  bubble / NOP word loaded into pipeline registers on flush
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam int REG_IDX_W = 5;

  localparam logic [31:0] NOP_INSTR = 32'd0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter used for pipeline statistics
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset, clears the count
//   inc_i    in   increment request for this cycle
//   count_o  out  current count, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - central stall/flush controller for the 5-stage pipeline
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i                      run enable; low freezes pipeline and controller state
//   idex_memread_i, idex_rd_i    load flag and destination of the instruction in EX
//   ifid_rs1_i, ifid_rs2_i       source registers of the instruction in ID
//   branch_taken_i               branch resolved taken in ID
//   mem_req_i, mem_ready_i       MEM-stage data access handshake
//   pc_write_o, ifid_write_o     PC / IF-ID load enables
//   ifid_flush_o                 IF/ID loads a NOP
//   idex_bubble_o                ID/EX loads a bubble
//   stage_hold_o                 ID/EX, EX/MEM, MEM/WB hold
//   err_o                        sticky memory-timeout error
//   state_o                      FSM state encoding
//   stall_cnt_o, flush_cnt_o     saturating statistics counters
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 idex_memread_i,
  input  logic [REG_IDX_W-1:0] idex_rd_i,
  input  logic [REG_IDX_W-1:0] ifid_rs1_i,
  input  logic [REG_IDX_W-1:0] ifid_rs2_i,
  input  logic                 branch_taken_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ready_i,
  output logic                 pc_write_o,
  output logic                 ifid_write_o,
  output logic                 ifid_flush_o,
  output logic                 idex_bubble_o,
  output logic                 stage_hold_o,
  output logic                 err_o,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o
);

  // wait_cnt never exceeds MEM_TIMEOUT-1
  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_err;

  state_e            w_state_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_err_nxt;
  logic              w_freeze;
  logic              w_load_use;
  logic              w_rs_match;

  assign w_rs_match = (idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i);
  assign w_load_use = idex_memread_i && (idex_rd_i != '0) && w_rs_match;

  // Freeze, load-use and flush resolution; freeze wins over load-use wins over flush
  always_comb begin
    w_freeze      = 1'b0;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    stage_hold_o  = 1'b0;

    case (r_state)
      ST_RUN:      w_freeze = mem_req_i && !mem_ready_i;
      ST_MEM_WAIT: w_freeze = !mem_ready_i;
      ST_ERROR:    w_freeze = 1'b1;
      default:     w_freeze = 1'b0;
    endcase
    if (!start_i) begin
      w_freeze = 1'b1;
    end

    if (w_freeze) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      stage_hold_o = 1'b1;
    end else if (w_load_use) begin
      // ID is held, so a coincident branch is re-presented next cycle
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  // Next-state logic; with start_i low everything holds
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_err_nxt   = r_err;

    if (start_i) begin
      case (r_state)
        ST_RUN: begin
          if (mem_req_i && !mem_ready_i) begin
            w_state_nxt = ST_MEM_WAIT;
            w_wait_nxt  = WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready_i) begin
            w_state_nxt = ST_RUN;
          end else if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = 1'b1;
          end else begin
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_ERROR: begin
          w_state_nxt = ST_ERROR;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign err_o   = r_err;
  assign state_o = r_state;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (start_i && !pc_write_o),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (ifid_flush_o),
    .count_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic             idex_memread_i = 1'b0;
  logic [4:0]       idex_rd_i = '0;
  logic [4:0]       ifid_rs1_i = '0;
  logic [4:0]       ifid_rs2_i = '0;
  logic             branch_taken_i = 1'b0;
  logic             mem_req_i = 1'b0;
  logic             mem_ready_i = 1'b0;
  logic             pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, stage_hold_o, err_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .idex_memread_i (idex_memread_i),
    .idex_rd_i      (idex_rd_i),
    .ifid_rs1_i     (ifid_rs1_i),
    .ifid_rs2_i     (ifid_rs2_i),
    .branch_taken_i (branch_taken_i),
    .mem_req_i      (mem_req_i),
    .mem_ready_i    (mem_ready_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .stage_hold_o   (stage_hold_o),
    .err_o          (err_o),
    .state_o        (state_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pcw, ifw, fl, bub, hold, err, st, sc, fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: "mode" 0 running, 1 waiting on memory, 2 failed.
  // m_frozen counts frozen cycles spent on the current memory access.
  int m_mode = 0, m_frozen = 0, m_err = 0, m_stall = 0, m_flush = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit st, input bit mr, input int rd,
                       input int r1, input int r2, input bit br, input bit rq, input bit rdy);
    exp_t e;
    bit   freeze, lu, mem_stuck;
    @(posedge clk);
    #1;
    rst_i = rst; start_i = st; idex_memread_i = mr;
    idex_rd_i = 5'(rd); ifid_rs1_i = 5'(r1); ifid_rs2_i = 5'(r2);
    branch_taken_i = br; mem_req_i = rq; mem_ready_i = rdy;

    mem_stuck = (m_mode == 0) ? (rq && !rdy) : (m_mode == 1) ? !rdy : 1'b1;
    freeze = !st || mem_stuck;
    lu = mr && (rd != 0) && (rd == r1 || rd == r2);
    e.err = m_err; e.st = m_mode; e.sc = m_stall; e.fc = m_flush;
    e.pcw = 1; e.ifw = 1; e.fl = 0; e.bub = 0; e.hold = 0;
    if (freeze) begin
      e.pcw = 0; e.ifw = 0; e.hold = 1;
    end else if (lu) begin
      e.pcw = 0; e.ifw = 0; e.bub = 1;
    end else if (br) begin
      e.fl = 1;
    end
    exp_q.push_back(e);

    if (rst) begin
      m_mode = 0; m_frozen = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else if (st) begin
      if (e.pcw == 0 && m_stall < CNT_MAX) m_stall++;
      if (e.fl == 1 && m_flush < CNT_MAX) m_flush++;
      if (m_mode == 0 && rq && !rdy) begin
        m_mode = 1; m_frozen = 1;
      end else if (m_mode == 1) begin
        if (rdy) m_mode = 0;
        else begin
          m_frozen++;
          if (m_frozen >= TIMEOUT) begin
            m_mode = 2; m_err = 1;
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_write",    int'(pc_write_o),    e.pcw);
        chk("ifid_write",  int'(ifid_write_o),  e.ifw);
        chk("ifid_flush",  int'(ifid_flush_o),  e.fl);
        chk("idex_bubble", int'(idex_bubble_o), e.bub);
        chk("stage_hold",  int'(stage_hold_o),  e.hold);
        chk("err",         int'(err_o),         e.err);
        chk("state",       int'(state_o),       e.st);
        chk("stall_cnt",   int'(stall_cnt_o),   e.sc);
        chk("flush_cnt",   int'(flush_cnt_o),   e.fc);
      end
    end
  end

  initial begin : stimulus
    int guard;
    repeat (2) @(posedge clk);

    // reset state, then idle running pipeline
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // load-use on rs2, then rd=0 must not stall
    cycle(0, 1, 1, 5, 1, 5, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // branch alone, then branch together with load-use
    cycle(0, 1, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 1, 1, 7, 7, 2, 1, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 1, 0, 0);

    // memory wait, ready three cycles after the request
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // start_i low for 5 cycles in MEM_WAIT, then release
    cycle(0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 3, 3, 0, 1, 1, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 1, 1);

    // timeout: ready never comes, error persists until reset
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0, 0, 1, 1, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // saturation: 10 consecutive load-use stalls
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 4, 4, 9, 0, 0, 0);
    idle(1);

    // rst_i mid-MEM_WAIT returns to RUN
    cycle(0, 1, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // randomized traffic with small register indices to hit hazards
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 79) == 0),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0));
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
